pc_sequencer: RTL

- Owns the program counter and selects its next value each cycle: sequential, conditional branch, jump or jump-register.
- Branch target uses the word-offset rule: PC+4 plus the sign-extended immediate shifted left by 2.
- Sits between fetch and decode. Holds fetch while a conditional branch outcome is pending from the ALU compare.
- Times out if the outcome never arrives.

---
 rtl/pc_sequencer.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//
// Owns the program counter between fetch and decode. Each cycle it selects the
// next PC from one of: sequential (PC+4), conditional branch, jump (J/JAL) or
// jump-register (JR). A conditional branch parks the sequencer in WAIT_COND
// until the ALU compare delivers its outcome. If the outcome never arrives,
// the branch is treated as not taken and a sticky timeout error is raised.
//
// Handshake: CondValid is a one-cycle qualifier for CondTaken. It is only
// consumed in WAIT_COND. Busy tells decode not to issue. Stall freezes the PC.
// The sequencer state still advances under Stall. Request inputs are level
// signals that decode keeps presenting until the PC moves past them.
//
// Ports:
//   Clk          rising-edge clock
//   Reset_n      asynchronous active-low reset
//   Stall        hold PC (pipeline hazard)
//   BranchReq    conditional branch decoded at current PC
//   BranchImm    signed word offset for the branch
//   JumpReq      J/JAL at current PC
//   JumpIndex    26-bit jump word index
//   JumpRegReq   JR at current PC
//   JumpRegAddr  JR target address
//   CondValid    branch outcome valid (single-cycle pulse)
//   CondTaken    branch outcome, qualified by CondValid
//   PC           current fetch address
//   PCPlus4      PC+4, combinational
//   Flush        one-cycle pulse the cycle after each redirect
//   Busy         high in WAIT_COND / RESOLVED
//   TimeoutErr   sticky, set when WAIT_COND times out
//   AlignErr     sticky, set on a JR target with [1:0] != 0
//   DbgState     current sequencer state (RUN=0, WAIT_COND=1, RESOLVED=2)
// -----------------------------------------------------------------------------
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          MAX_WAIT = 8,
    parameter int          CNT_W    = 4
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        Stall,
    input  logic        BranchReq,
    input  logic [15:0] BranchImm,
    input  logic        JumpReq,
    input  logic [25:0] JumpIndex,
    input  logic        JumpRegReq,
    input  logic [31:0] JumpRegAddr,
    input  logic        CondValid,
    input  logic        CondTaken,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic        Flush,
    output logic        Busy,
    output logic        TimeoutErr,
    output logic        AlignErr,
    output logic [1:0]  DbgState
);

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_WAIT_COND = 2'd1,
        ST_RESOLVED  = 2'd2
    } state_t;

    // Last counter value that is still waited out before the timeout fires.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

    state_t           r_state;
    logic [31:0]      r_pc;
    logic [31:0]      r_br_target;
    logic [31:0]      r_fallthrough;
    logic [CNT_W-1:0] r_cnt;
    logic             r_taken;
    logic             r_flush;
    logic             r_busy;
    logic             r_timeout_err;
    logic             r_align_err;

    logic [31:0]      w_pc_plus4;
    logic [31:0]      w_br_offset;
    logic [31:0]      w_br_target;
    logic [31:0]      w_j_target;
    logic [31:0]      w_resolved_pc;

    // All target arithmetic is modulo 2^32; wrap-around is intentional.
    assign w_pc_plus4  = r_pc + 32'd4;
    assign w_br_offset = {{14{BranchImm[15]}}, BranchImm, 2'b00};
    assign w_br_target = w_pc_plus4 + w_br_offset;
    // The jump keeps the 256 MB region of the delay-slot address (PC+4).
    assign w_j_target  = {w_pc_plus4[31:28], JumpIndex, 2'b00};

    // PC chosen by a latched outcome when leaving RESOLVED.
    assign w_resolved_pc = r_taken ? r_br_target : r_fallthrough;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state       <= ST_RUN;
            r_pc          <= RESET_PC;
            r_br_target   <= 32'd0;
            r_fallthrough <= 32'd0;
            r_cnt         <= '0;
            r_taken       <= 1'b0;
            r_flush       <= 1'b0;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b0;
            r_align_err   <= 1'b0;
        end else begin
            // Flush is a single-cycle pulse; only a redirect edge re-arms it.
            r_flush <= 1'b0;

            case (r_state)
                ST_RUN: begin
                    // Under Stall every request is dropped; decode re-presents it.
                    if (!Stall) begin
                        if (JumpRegReq) begin
                            r_pc    <= JumpRegAddr;
                            r_flush <= 1'b1;
                            // The misaligned address is still loaded; the error
                            // is reported, not corrected.
                            if (JumpRegAddr[1:0] != 2'b00) begin
                                r_align_err <= 1'b1;
                            end
                        end else if (JumpReq) begin
                            r_pc    <= w_j_target;
                            r_flush <= 1'b1;
                        end else if (BranchReq) begin
                            // Capture both possible next PCs now so that the
                            // outcome can be applied without re-reading inputs.
                            r_br_target   <= w_br_target;
                            r_fallthrough <= w_pc_plus4;
                            r_cnt         <= '0;
                            r_state       <= ST_WAIT_COND;
                            r_busy        <= 1'b1;
                        end else begin
                            r_pc <= w_pc_plus4;
                        end
                    end
                end

                ST_WAIT_COND: begin
                    if (CondValid) begin
                        // A valid outcome beats a coinciding timeout.
                        if (Stall) begin
                            r_taken <= CondTaken;
                            r_state <= ST_RESOLVED;
                        end else begin
                            r_pc    <= CondTaken ? r_br_target : r_fallthrough;
                            r_flush <= CondTaken;
                            r_state <= ST_RUN;
                            r_busy  <= 1'b0;
                        end
                    end else if (r_cnt == CNT_LAST) begin
                        // Timeout: fall through as if not taken.
                        r_timeout_err <= 1'b1;
                        if (Stall) begin
                            r_taken <= 1'b0;
                            r_state <= ST_RESOLVED;
                        end else begin
                            r_pc    <= r_fallthrough;
                            r_state <= ST_RUN;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                ST_RESOLVED: begin
                    // Outcome already known; only the stall holds us here.
                    if (!Stall) begin
                        r_pc    <= w_resolved_pc;
                        r_flush <= r_taken;
                        r_state <= ST_RUN;
                        r_busy  <= 1'b0;
                    end
                end

                default: begin
                    r_state <= ST_RUN;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign PC         = r_pc;
    assign PCPlus4    = w_pc_plus4;
    assign Flush      = r_flush;
    assign Busy       = r_busy;
    assign TimeoutErr = r_timeout_err;
    assign AlignErr   = r_align_err;
    assign DbgState   = r_state;

endmodule
